// File: rtl/bcd_serial_add_ctrl.sv
// Serial multi-digit BCD adder: one decimal digit per clock, LSD first,
// with the decimal carry rippled through a register between digits.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [W-1:0]     a_reg, a_next;
    logic [W-1:0]     b_reg, b_next;
    logic [W-1:0]     sum_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             carry, carry_next;
    logic             cout_next, err_next;

    logic [3:0]       a_dig, b_dig, s_dig;
    logic [4:0]       raw;
    logic             dig_carry;

    // Single-digit BCD stage; the +6 correction wraps mod 16 like the 5-bit rule
    always_comb begin
        a_dig     = a_reg[4*idx +: 4];
        b_dig     = b_reg[4*idx +: 4];
        raw       = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        s_dig     = raw[3:0];
        dig_carry = 1'b0;
        if (raw > 5'd9) begin
            s_dig     = raw[3:0] + 4'd6;
            dig_carry = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum;
        idx_next   = idx;
        carry_next = carry;
        cout_next  = cout;
        err_next   = err;
        case (state)
            S_IDLE, S_DONE: begin
                state_next = S_IDLE;
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = cin;
                    idx_next   = '0;
                    sum_next   = '0;
                    err_next   = 1'b0;
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                sum_next[4*idx +: 4] = s_dig;
                err_next   = err | (a_dig > 4'd9) | (b_dig > 4'd9);
                carry_next = dig_carry;
                if (idx == LAST_IDX) begin
                    cout_next  = dig_carry;
                    state_next = S_DONE;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            a_reg <= a_next;
            b_reg <= b_next;
            sum   <= sum_next;
            idx   <= idx_next;
            carry <= carry_next;
            cout  <= cout_next;
            err   <= err_next;
        end
    end

    assign busy = (state == S_ADD);
    assign done = (state == S_DONE);

endmodule
